// File: rtl/uart_tx_sched_if.sv
// FIFO read port, TX enable and serial-side status of uart_tx_sched.
// `UART_TX_PARITY_EN adds the parity_odd select to the bundle.
`timescale 1ns/1ps
interface uart_tx_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  txd;
  logic                  busy;
  logic                  frame_done;
`ifdef UART_TX_PARITY_EN
  logic                  parity_odd;

  modport master (
    output tx_en, fifo_empty, fifo_dout, parity_odd,
    input  fifo_rd_en, txd, busy, frame_done
  );
  modport slave (
    input  tx_en, fifo_empty, fifo_dout, parity_odd,
    output fifo_rd_en, txd, busy, frame_done
  );
`else
  modport master (
    output tx_en, fifo_empty, fifo_dout,
    input  fifo_rd_en, txd, busy, frame_done
  );
  modport slave (
    input  tx_en, fifo_empty, fifo_dout,
    output fifo_rd_en, txd, busy, frame_done
  );
`endif
endinterface

// File: rtl/uart_tx_sched.sv
// Pops one byte per frame from a show-ahead FIFO and serialises it as 8N1/8N2 on txd.
// `UART_TX_PARITY_EN inserts a parity bit (even, or odd with parity_odd=1) before the stop bits.
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic            i_clk,
  input  logic            i_sclr,
  uart_tx_sched_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam bit STOP_TWO = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_stop_cnt;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_frame_done;

  state_t                w_state_nxt;
  logic [BAUD_W-1:0]     w_baud_nxt;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_stop_nxt;
  logic                  w_txd_nxt;
  logic                  w_done_nxt;
  logic                  w_pop;
  logic                  w_bit_end;

`ifdef UART_TX_PARITY_EN
  logic                  r_par;
  logic                  w_par_nxt;
`endif

  assign w_pop     = (r_state == S_IDLE) && bus.tx_en && !bus.fifo_empty && !i_sclr;
  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_stop_nxt  = r_stop_cnt;
    w_txd_nxt   = 1'b1;
    w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_shift_nxt = bus.fifo_dout;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_stop_nxt  = 1'b0;
          w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = (^bus.fifo_dout) ^ bus.parity_odd;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_cnt == BIT_LAST) begin
            w_stop_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!STOP_TWO || r_stop_cnt) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = w_par_nxt;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
    w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST) &&
                 (!STOP_TWO || w_stop_nxt);
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_stop_cnt   <= 1'b0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_baud_cnt   <= w_baud_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_stop_cnt   <= w_stop_nxt;
      r_txd        <= w_txd_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

  assign bus.fifo_rd_en = w_pop;
  assign bus.txd        = r_txd;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Consumes bytes from the UART TX sync FIFO and serialises them onto the TX line as 8N1 (or 8N2) frames.
- Owns the FIFO read port. Pops one byte per frame and times every bit with an internal baud divider.
- Sits between the TX FIFO (show-ahead: dout valid while !empty, rd_en pops) and the txd pad.

Parameters:
- DATA_WIDTH, 8, bits per character, sent LSB first.
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal ≥ 2.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- sclr  in  1  synchronous, active-high reset.
- tx_en  in  1  1 = may start new frames; 0 = finish current frame, then hold idle.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO head word, valid when fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to FIFO.
- txd  out  1  serial line, idle high.
- busy  out  1  1 while a frame is in progress (any state but IDLE).
- frame_done  out  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset: sclr=1 at a rising edge forces state=IDLE, txd=1, busy=0, frame_done=0, baud counter=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame immediately; txd returns high next cycle.
  - The aborted byte is lost; it was already popped.
- fifo_rd_en is combinational: fifo_rd_en = (state==IDLE) && tx_en && !fifo_empty && !sclr. Never asserted in any other state, so at most one pop per frame.
- States:
  - IDLE: txd=1.
    - On a pop cycle: shift_reg <= fifo_dout, baud_cnt <= 0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: txd=shift_reg[0] for CLKS_PER_BIT cycles per bit. Shift right and increment bit_cnt at each bit end. After bit DATA_WIDTH-1, go to PARITY (if enabled) or STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle: frame_done=1, go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps; the bit ends on the cycle with baud_cnt==CLKS_PER_BIT-1.
  - Width is $clog2(CLKS_PER_BIT).
- Latency:
  - txd falls on the first edge after the pop cycle.
  - Frame length = (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- Back-to-back frames: exactly one IDLE cycle (txd=1) separates consecutive frames when the FIFO stays non-empty.
- tx_en deasserted mid-frame: the current frame completes unchanged; no pop in IDLE until tx_en=1.
- fifo_empty rising mid-frame: no effect on the frame; the byte is already captured.
- Outputs txd, busy and frame_done are registered (glitch-free). fifo_rd_en is the only combinational output.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds input parity_odd (1 bit), sampled at the pop cycle.
  - Adds a PARITY state between DATA and STOP. txd = ^byte ^ parity_odd for CLKS_PER_BIT cycles.
  - The parity value is computed at capture time and stored in a flop.
- When undefined:
  - No parity_odd port, no PARITY state.
  - Frame is start + data + stop only.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Single byte: FIFO holds 0xA5, tx_en=1.
  - Required: one fifo_rd_en pulse.
  - txd = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clks.
  - frame_done pulses at cycle 40 after the pop; busy high for 40 cycles.
- Back-to-back: FIFO holds 0x00, 0xFF.
  - Required: two pops 41 cycles apart; exactly 1 idle-high cycle between frames.
  - Second frame data bits all 1.
- tx_en gating: tx_en dropped at data bit 3 of a 0x3C frame with FIFO non-empty.
  - Required: the frame completes intact; no further pop while tx_en=0.
  - Re-asserting tx_en pops on the same cycle.
- Empty FIFO: fifo_empty=1, tx_en=1 for 100 cycles.
  - Required: fifo_rd_en=0, txd=1, busy=0 throughout.
- Reset mid-frame: sclr=1 during data bit 5.
  - Required: next cycle txd=1, busy=0, state IDLE.
  - After sclr=0 with the FIFO non-empty, a new frame starts with a fresh start bit.
- STOP_BITS=2 and UART_TX_PARITY_EN with parity_odd=0, byte 0x07.
  - Required: parity bit = 1; stop high for 8 clks; frame = 48 clks.
